// File: rtl/gnss_iq_pkg.sv
// ---------------------------------------------------------------------------
// gnss_iq_pkg
// Shared types for the interleaved signed-8-bit IQ capture path.
//   iq_byte_t  : one signed output byte (I or Q)
//   iq_pair_t  : one stored I/Q pair, I in the upper byte, Q in the lower byte
//   pk_state_t : capture controller states
//   make_pair  : builds an iq_pair_t from two already-extended bytes
// ---------------------------------------------------------------------------
package gnss_iq_pkg;

    typedef logic signed [7:0] iq_byte_t;

    typedef struct packed {
        iq_byte_t i;
        iq_byte_t q;
    } iq_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        DONE
    } pk_state_t;

    function automatic iq_pair_t make_pair(input iq_byte_t i, input iq_byte_t q);
        iq_pair_t p;
        p.i = i;
        p.q = q;
        return p;
    endfunction

endpackage

// File: rtl/iq_pair_fifo.sv
// ---------------------------------------------------------------------------
// iq_pair_fifo
// Synchronous FIFO of I/Q pairs. The head entry is read straight out of the
// storage registers, so a pair written on one edge is visible at o_head in
// the very next cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_wr_en    : write request (ignored while full)
//   i_wr_data  : pair to store
//   i_rd_en    : pop request (ignored while empty)
//   o_head     : oldest stored pair
//   o_full     : DEPTH pairs stored
//   o_empty    : nothing stored
// ---------------------------------------------------------------------------
module iq_pair_fifo
    import gnss_iq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_wr_en,
    input  iq_pair_t i_wr_data,
    input  logic     i_rd_en,
    output iq_pair_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);

    iq_pair_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_wr;
    logic            w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Full is judged on the registered count, so a write offered while full
    // is lost even if the same cycle pops an entry.
    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    // Storage array: no reset needed, contents are only observed while the
    // count says they are valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iq_byte_packer.sv
// ---------------------------------------------------------------------------
// iq_byte_packer
// Packs quantised I/Q samples into an interleaved signed-byte stream
// (I byte then Q byte) for the capture sink, framing captures of a
// programmed number of pairs.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cap_start/cap_len : start a capture of cap_len pairs (only from IDLE)
//   s_valid/s_i/s_q   : one signed I/Q pair per asserted cycle, no backpressure
//   m_valid/m_ready   : output byte handshake
//   m_data/m_is_q     : output byte and its phase (0 = I, 1 = Q)
//   busy              : capture or drain in progress
//   done              : one-cycle pulse when the capture has fully drained
//   ovf/ovf_cnt       : pairs dropped this capture (sticky flag, saturating count)
// ---------------------------------------------------------------------------
module iq_byte_packer
    import gnss_iq_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int DEPTH = 16,
    parameter int LEN_W = 24,
    parameter int OVF_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_start,
    input  logic [LEN_W-1:0] cap_len,
    input  logic             s_valid,
    input  logic [IN_W-1:0]  s_i,
    input  logic [IN_W-1:0]  s_q,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_is_q,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [OVF_W-1:0] ovf_cnt
);

    pk_state_t          r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_phase;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic [OVF_W-1:0]   r_ovf_cnt;

    iq_pair_t           w_head;
    iq_pair_t           w_wr_data;
    logic               w_full;
    logic               w_empty;
    logic               w_take;
    logic               w_wr_en;
    logic               w_handshake;
    logic               w_pop;

    // Signed casts replicate the sample sign bit up to bit 7.
    assign w_wr_data = make_pair(iq_byte_t'($signed(s_i)), iq_byte_t'($signed(s_q)));

    assign w_take      = (r_state == CAPTURE) && s_valid;
    assign w_wr_en     = w_take && !w_full;
    assign w_handshake = m_valid && m_ready;
    assign w_pop       = w_handshake && r_phase;

    iq_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Serialiser: the head pair stays put until its Q byte is accepted, so
    // the presented byte cannot change during a stall.
    assign m_valid = !w_empty;
    assign m_is_q  = r_phase;
    assign m_data  = !m_valid ? 8'h00 : (r_phase ? w_head.q : w_head.i);

    assign busy    = r_busy;
    assign done    = r_done;
    assign ovf     = r_ovf;
    assign ovf_cnt = r_ovf_cnt;

    // Capture controller. The remaining-pair counter is loaded with cap_len
    // at start and decremented on every offered pair, dropped or not, which
    // keeps the capture a fixed time window. busy/done are registered
    // alongside the state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_phase     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_ovf_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_handshake) begin
                r_phase <= ~r_phase;
            end
            case (r_state)
                IDLE: begin
                    if (cap_start) begin
                        r_ovf       <= 1'b0;
                        r_ovf_cnt   <= '0;
                        r_remaining <= cap_len;
                        if (cap_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= CAPTURE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (s_valid) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_full) begin
                            r_ovf <= 1'b1;
                            if (r_ovf_cnt != '1) begin
                                r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
                            end
                        end
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty && !r_phase) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_iq_byte_packer
// Scenario-driven bench for iq_byte_packer. A queue-based reference model
// predicts the output byte stream from the sample stream, the capture length
// and the FIFO depth; every cycle the presented byte is compared with it.
// ---------------------------------------------------------------------------
module tb_iq_byte_packer;

    localparam int IN_W  = 3;
    localparam int DEPTH = 16;
    localparam int LEN_W = 24;
    localparam int OVF_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cap_start;
    logic [LEN_W-1:0] cap_len;
    logic             s_valid;
    logic [IN_W-1:0]  s_i;
    logic [IN_W-1:0]  s_q;
    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_data;
    logic             m_is_q;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [OVF_W-1:0] ovf_cnt;

    iq_byte_packer #(
        .IN_W  (IN_W),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W),
        .OVF_W (OVF_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_start (cap_start),
        .cap_len   (cap_len),
        .s_valid   (s_valid),
        .s_i       (s_i),
        .s_q       (s_q),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_is_q    (m_is_q),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       q;
    } exp_byte_t;

    // Reference model state: bytes still owed to the sink, pairs held in the
    // FIFO, capture window bookkeeping and the drop count.
    exp_byte_t expQ[$];
    int        occ;
    int        mRem;
    int        mOvf;
    bit        mCap;
    bit        mIdle;

    int        nChecks;
    int        nFail;

    // Signed value of the sample, written out as an 8-bit two's complement byte.
    function automatic logic [7:0] sext(input logic [IN_W-1:0] v);
        int x;
        x = int'(v);
        if (x >= 2**(IN_W-1)) x = x - 2**IN_W;
        return x[7:0];
    endfunction

    // One clock cycle, entered and left at a falling edge. Samples the DUT
    // outputs and the model prediction, applies inputs, advances the model.
    task automatic cycle(input logic sv, input logic [IN_W-1:0] si, input logic [IN_W-1:0] sq,
                         input logic rdy, input logic start, input logic [LEN_W-1:0] len,
                         output logic [9:0] obs, output logic [9:0] expv, output logic obsDone);
        bit        fullBefore;
        exp_byte_t e;
        obs     = {m_valid, m_is_q, m_data};
        expv    = (expQ.size() > 0) ? {1'b1, expQ[0].q, expQ[0].b} : 10'd0;
        obsDone = done;
        s_valid   = sv;
        s_i       = si;
        s_q       = sq;
        m_ready   = rdy;
        cap_start = start;
        cap_len   = len;
        fullBefore = (occ == DEPTH);
        if (rdy && expQ.size() > 0) begin
            e = expQ.pop_front();
            if (e.q) occ--;
        end
        if (mCap && sv) begin
            mRem--;
            if (fullBefore) begin
                mOvf++;
            end else begin
                expQ.push_back('{b: sext(si), q: 1'b0});
                expQ.push_back('{b: sext(sq), q: 1'b1});
                occ++;
            end
            if (mRem == 0) mCap = 0;
        end
        if (start && mIdle) begin
            mIdle = 0;
            mOvf  = 0;
            if (len != '0) begin
                mCap = 1;
                mRem = int'(len);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        rst       = 1'b1;
        cap_start = 1'b0;
        cap_len   = '0;
        s_valid   = 1'b0;
        s_i       = '0;
        s_q       = '0;
        m_ready   = 1'b0;
        occ = 0; mRem = 0; mOvf = 0; mCap = 0; mIdle = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        nChecks++;
        if ({m_valid, m_data, m_is_q, busy, done, ovf, ovf_cnt} !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_state: got v=%b d=%h q=%b busy=%b done=%b ovf=%b cnt=%0d, want all zero",
                     m_valid, m_data, m_is_q, busy, done, ovf, ovf_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [9:0] obs, expv;
        logic       dn;
        logic [8:0] got[$];
        logic [8:0] want [4];
        int         dones;
        want  = '{9'h003, 9'h1FC, 9'h0FF, 9'h101};
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 0)      cycle(1'b0, 3'b000, 3'b000, 1'b1, 1'b1, LEN_W'(2), obs, expv, dn);
            else if (c == 1) cycle(1'b1, 3'b011, 3'b100, 1'b1, 1'b0, '0, obs, expv, dn);
            else if (c == 2) cycle(1'b1, 3'b111, 3'b001, 1'b1, 1'b0, '0, obs, expv, dn);
            else             cycle(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, '0, obs, expv, dn);
            nChecks++;
            if (obs !== expv) begin
                nFail++;
                $display("[TB] FAIL basic_byte c=%0d: got %h, want %h", c, obs, expv);
            end
            if (obs[9]) got.push_back(obs[8:0]);
            if (dn) dones++;
        end
        nChecks++;
        if (got.size() != 4) begin
            nFail++;
            $display("[TB] FAIL basic_count: got %0d bytes, want 4", got.size());
        end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            nChecks++;
            if (got[k] !== want[k]) begin
                nFail++;
                $display("[TB] FAIL basic_seq[%0d]: got q=%b d=%h, want q=%b d=%h",
                         k, got[k][8], got[k][7:0], want[k][8], want[k][7:0]);
            end
        end
        nChecks++;
        if (dones != 1) begin
            nFail++;
            $display("[TB] FAIL basic_done: got %0d pulses, want 1", dones);
        end
        mIdle = 1;
    endtask

    task automatic test_backpressure();
        logic [9:0] obs, expv, prevObs;
        logic       dn, rdy, prevStall;
        int         dones, c;
        prevStall = 1'b0;
        prevObs   = '0;
        cycle(1'b0, '0, '0, 1'b0, 1'b1, LEN_W'(100), obs, expv, dn);
        c = 0;
        while (c < 2000 && (mCap || expQ.size() > 0)) begin
            rdy = ($urandom_range(9) < 7);
            cycle((c % 4) == 0, IN_W'($urandom()), IN_W'($urandom()), rdy, 1'b0, '0, obs, expv, dn);
            nChecks++;
            if (obs !== expv) begin
                nFail++;
                $display("[TB] FAIL bp_byte c=%0d: got %h, want %h", c, obs, expv);
            end
            if (prevStall) begin
                nChecks++;
                if (obs !== prevObs) begin
                    nFail++;
                    $display("[TB] FAIL bp_hold c=%0d: got %h, want held %h", c, obs, prevObs);
                end
            end
            prevStall = obs[9] && !rdy;
            prevObs   = obs;
            c++;
        end
        nChecks++;
        if (ovf !== 1'b0 || ovf_cnt !== '0) begin
            nFail++;
            $display("[TB] FAIL bp_ovf: got ovf=%b cnt=%0d, want 0/0", ovf, ovf_cnt);
        end
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, obs, expv, dn);
            if (dn) dones++;
        end
        nChecks++;
        if (dones != 1) begin
            nFail++;
            $display("[TB] FAIL bp_done: got %0d pulses, want 1", dones);
        end
        mIdle = 1;
    endtask

    task automatic test_overflow();
        logic [9:0] obs, expv;
        logic       dn;
        int         dones, popped;
        cycle(1'b0, '0, '0, 1'b0, 1'b1, LEN_W'(20), obs, expv, dn);
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, IN_W'($urandom()), IN_W'($urandom()), 1'b0, 1'b0, '0, obs, expv, dn);
            nChecks++;
            if (obs !== expv) begin
                nFail++;
                $display("[TB] FAIL ovf_byte c=%0d: got %h, want %h", c, obs, expv);
            end
        end
        nChecks++;
        if (ovf !== 1'b1 || ovf_cnt !== OVF_W'(4) || busy !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL ovf_flags: got ovf=%b cnt=%0d busy=%b, want 1/4/1", ovf, ovf_cnt, busy);
        end
        popped = 0;
        for (int c = 0; c < 100 && expQ.size() > 0; c++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, obs, expv, dn);
            nChecks++;
            if (obs !== expv) begin
                nFail++;
                $display("[TB] FAIL ovf_drain c=%0d: got %h, want %h", c, obs, expv);
            end
            if (obs[9]) popped++;
        end
        nChecks++;
        if (popped != 32) begin
            nFail++;
            $display("[TB] FAIL ovf_popped: got %0d bytes, want 32", popped);
        end
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, obs, expv, dn);
            if (dn) dones++;
        end
        nChecks++;
        if (dones != 1 || ovf !== 1'b1 || ovf_cnt !== OVF_W'(4)) begin
            nFail++;
            $display("[TB] FAIL ovf_done: got %0d pulses ovf=%b cnt=%0d, want 1 pulse, 1/4 held",
                     dones, ovf, ovf_cnt);
        end
        mIdle = 1;
    endtask

    task automatic test_zero_len();
        logic [9:0] obs, expv;
        logic       dn;
        int         dones, firstDone;
        cycle(1'b0, '0, '0, 1'b1, 1'b1, '0, obs, expv, dn);
        dones = 0;
        firstDone = -1;
        for (int k = 1; k <= 4; k++) begin
            nChecks++;
            if (busy !== 1'b0 || m_valid !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL zero_busy k=%0d: got busy=%b valid=%b, want 0/0", k, busy, m_valid);
            end
            cycle(1'b1, '0, '0, 1'b1, 1'b0, '0, obs, expv, dn);
            if (dn) begin
                dones++;
                if (firstDone < 0) firstDone = k;
            end
        end
        nChecks++;
        if (dones != 1 || firstDone < 1 || firstDone > 2) begin
            nFail++;
            $display("[TB] FAIL zero_done: got %0d pulses first at %0d, want 1 at cycle 1..2",
                     dones, firstDone);
        end
        mIdle = 1;
    endtask

    task automatic test_reset_mid();
        logic [9:0] obs, expv;
        logic       dn;
        int         dones;
        cycle(1'b0, '0, '0, 1'b0, 1'b1, LEN_W'(20), obs, expv, dn);
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, IN_W'($urandom()), IN_W'($urandom()), 1'b0, 1'b0, '0, obs, expv, dn);
        end
        nChecks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL mid_queued: got valid=%b busy=%b, want 1/1", m_valid, busy);
        end
        rst = 1'b1;
        #1;
        nChecks++;
        if ({m_valid, m_data, m_is_q, busy, done, ovf, ovf_cnt} !== '0) begin
            nFail++;
            $display("[TB] FAIL mid_reset: got v=%b d=%h q=%b busy=%b done=%b, want all zero",
                     m_valid, m_data, m_is_q, busy, done);
        end
        expQ.delete();
        occ = 0; mCap = 0; mOvf = 0; mRem = 0; mIdle = 1;
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, obs, expv, dn);
            if (dn) dones++;
        end
        nChecks++;
        if (dones != 0) begin
            nFail++;
            $display("[TB] FAIL mid_nodone: got %0d pulses, want 0", dones);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b1, LEN_W'(3), obs, expv, dn);
        for (int c = 0; c < 20; c++) begin
            cycle(c < 3, IN_W'($urandom()), IN_W'($urandom()), 1'b1, 1'b0, '0, obs, expv, dn);
            nChecks++;
            if (obs !== expv) begin
                nFail++;
                $display("[TB] FAIL mid_restart c=%0d: got %h, want %h", c, obs, expv);
            end
            if (dn) dones++;
        end
        nChecks++;
        if (dones != 1) begin
            nFail++;
            $display("[TB] FAIL mid_restart_done: got %0d pulses, want 1", dones);
        end
        mIdle = 1;
    endtask

    task automatic test_start_ignored();
        logic [9:0] obs, expv;
        logic       dn;
        int         dones;
        cycle(1'b0, '0, '0, 1'b1, 1'b1, LEN_W'(6), obs, expv, dn);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            cycle((c % 2) == 0, IN_W'($urandom()), IN_W'($urandom()), 1'b1, c == 3,
                  LEN_W'(2), obs, expv, dn);
            nChecks++;
            if (obs !== expv) begin
                nFail++;
                $display("[TB] FAIL ign_byte c=%0d: got %h, want %h", c, obs, expv);
            end
            if (dn) dones++;
        end
        nChecks++;
        if (dones != 1 || busy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL ign_done: got %0d pulses busy=%b, want 1/0", dones, busy);
        end
        mIdle = 1;
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        applyStimulus();
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_zero_len();
        test_reset_mid();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
